// File: rtl/afifo_pkg.sv
// Shared types and constants for the async FIFO read-side drain logic.
package afifo_pkg;

    localparam int DSIZE_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } drain_state_e;

    typedef logic [DSIZE_DEF-1:0] afifo_word_t;

    // Entries thrown away when the skid buffer is cleared: a word that
    // transfers downstream on that same edge still counts as delivered.
    function automatic logic [1:0] skid_discard(input logic [1:0] cnt, input logic xfer);
        return cnt - {1'b0, xfer};
    endfunction

endpackage

// File: rtl/afifo_rd_drain_if.sv
// FIFO read port plus downstream valid/ready stream, seen from the drain block.
interface afifo_rd_drain_if #(
    parameter int DSIZE = afifo_pkg::DSIZE_DEF
);
    logic             rd_empty;
    logic [DSIZE-1:0] rd_data;
    logic             rd_inc;
    logic [DSIZE-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        input  rd_empty, rd_data, out_ready,
        output rd_inc, out_data, out_valid
    );

    modport slave (
        output rd_empty, rd_data, out_ready,
        input  rd_inc, out_data, out_valid
    );
endinterface

// File: rtl/afifo_skid_buf.sv
// Two-entry FIFO-ordered valid/ready buffer with a registered head word.
module afifo_skid_buf
    import afifo_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             clear,
    input  logic             push,
    input  logic [DSIZE-1:0] push_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [DSIZE-1:0] out_data,
    output logic [1:0]       cnt
);

    logic [DSIZE-1:0] head_reg;
    logic [DSIZE-1:0] tail_reg;
    logic [1:0]       cnt_reg;
    logic             xfer;

    assign xfer      = (cnt_reg != 2'd0) && out_ready;
    assign out_valid = (cnt_reg != 2'd0);
    assign out_data  = head_reg;
    assign cnt       = cnt_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            head_reg <= '0;
            tail_reg <= '0;
            cnt_reg  <= 2'd0;
        end else if (clear) begin
            cnt_reg <= 2'd0;
        end else if (push && !xfer) begin
            if (cnt_reg == 2'd0) begin
                head_reg <= push_data;
                cnt_reg  <= 2'd1;
            end else if (cnt_reg == 2'd1) begin
                tail_reg <= push_data;
                cnt_reg  <= 2'd2;
            end
        end else if (!push && xfer) begin
            // Head only advances when a second word is waiting behind it.
            if (cnt_reg == 2'd2) begin
                head_reg <= tail_reg;
            end
            cnt_reg <= cnt_reg - 2'd1;
        end else if (push && xfer) begin
            if (cnt_reg == 2'd2) begin
                head_reg <= tail_reg;
                tail_reg <= push_data;
            end else begin
                head_reg <= push_data;
            end
        end
    end

endmodule

// File: rtl/afifo_rd_drain.sv
// Read-domain consumer for the async FIFO: streams words out through a skid
// buffer, supports flushing, and counts pops and discarded words.
module afifo_rd_drain
    import afifo_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int CNTW  = 16
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  en,
    input  logic                  flush,
    afifo_rd_drain_if.master      bus,
    output logic                  busy,
    output logic [CNTW-1:0]       pop_count,
    output logic [CNTW-1:0]       drop_count
);

    drain_state_e    state_reg;
    logic            busy_reg;
    logic [CNTW-1:0] pop_count_reg;
    logic [CNTW-1:0] drop_count_reg;
    logic [CNTW-1:0] drop_count_next;

    logic            rd_inc_w;
    logic            flush_entry;
    logic            push;
    logic            xfer;
    logic            pop_dropped;
    logic [1:0]      skid_cnt;
    logic [1:0]      discard;

    assign rd_inc_w = (((state_reg == STREAM) && (skid_cnt < 2'd2)) || (state_reg == FLUSH))
                      && !bus.rd_empty && !rd_rst;
    assign bus.rd_inc = rd_inc_w;

    // A flush request only matters outside FLUSH; re-requests are ignored.
    assign flush_entry = flush && (state_reg != FLUSH);
    assign push        = rd_inc_w && (state_reg == STREAM) && !flush_entry;
    assign xfer        = bus.out_valid && bus.out_ready;
    assign pop_dropped = rd_inc_w && ((state_reg == FLUSH) || flush_entry);
    assign discard     = flush_entry ? skid_discard(skid_cnt, xfer) : 2'd0;

    always_comb begin
        drop_count_next = drop_count_reg + CNTW'(discard) + CNTW'(pop_dropped);
    end

    afifo_skid_buf #(.DSIZE(DSIZE)) u_skid (
        .clk       (rd_clk),
        .srst      (rd_rst),
        .clear     (flush_entry),
        .push      (push),
        .push_data (bus.rd_data),
        .out_ready (bus.out_ready),
        .out_valid (bus.out_valid),
        .out_data  (bus.out_data),
        .cnt       (skid_cnt)
    );

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state_reg      <= IDLE;
            busy_reg       <= 1'b0;
            pop_count_reg  <= '0;
            drop_count_reg <= '0;
        end else begin
            if (rd_inc_w) begin
                pop_count_reg <= pop_count_reg + CNTW'(1);
            end
            drop_count_reg <= drop_count_next;

            case (state_reg)
                IDLE: begin
                    if (flush) begin
                        state_reg <= FLUSH;
                        busy_reg  <= 1'b1;
                    end else if (en) begin
                        state_reg <= STREAM;
                    end
                end
                STREAM: begin
                    if (flush) begin
                        state_reg <= FLUSH;
                        busy_reg  <= 1'b1;
                    end else if (!en) begin
                        state_reg <= IDLE;
                    end
                end
                FLUSH: begin
                    if (bus.rd_empty) begin
                        state_reg <= en ? STREAM : IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_reg;
    assign pop_count  = pop_count_reg;
    assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_afifo_rd_drain.sv
// Directed bench for afifo_rd_drain with a queue-based FIFO model on the read port.
module tb_afifo_rd_drain;

    logic        clk;
    logic        rd_rst;
    logic        en;
    logic        flush;
    logic        busy;
    logic [15:0] pop_count;
    logic [15:0] drop_count;

    logic        wrap_busy;
    logic [7:0]  wrap_pop;
    logic [7:0]  wrap_drop;

    int errors = 0;
    int checks = 0;
    logic [7:0] fq[$];

    afifo_rd_drain_if #(.DSIZE(8)) bus ();
    afifo_rd_drain_if #(.DSIZE(8)) wbus ();

    afifo_rd_drain #(.DSIZE(8), .CNTW(16)) dut (
        .rd_clk     (clk),
        .rd_rst     (rd_rst),
        .en         (en),
        .flush      (flush),
        .bus        (bus),
        .busy       (busy),
        .pop_count  (pop_count),
        .drop_count (drop_count)
    );

    // Narrow-counter instance on an always-full FIFO, used for the wrap check.
    afifo_rd_drain #(.DSIZE(8), .CNTW(8)) u_wrap (
        .rd_clk     (clk),
        .rd_rst     (rd_rst),
        .en         (1'b1),
        .flush      (1'b0),
        .bus        (wbus),
        .busy       (wrap_busy),
        .pop_count  (wrap_pop),
        .drop_count (wrap_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_fifo();
        bus.rd_empty = (fq.size() == 0);
        bus.rd_data  = (fq.size() == 0) ? 8'h00 : fq[0];
    endtask

    // One clock: capture the pop decision before the edge, retire it after.
    task automatic tick();
        logic p;
        #1;
        p = bus.rd_inc;
        @(posedge clk);
        @(negedge clk);
        if (p && fq.size() != 0) void'(fq.pop_front());
        drive_fifo();
        #1;
    endtask

    task automatic test_reset();
        fq = '{8'h01, 8'h02, 8'h03};
        drive_fifo();
        rd_rst = 1'b1;
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (bus.rd_inc !== 1'b0) begin errors++; $display("FAIL reset_rd_inc cyc%0d: got %b want 0", i, bus.rd_inc); end
            checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid cyc%0d: got %b want 0", i, bus.out_valid); end
            checks++; if (pop_count !== 16'h0) begin errors++; $display("FAIL reset_pop_count cyc%0d: got %h want 0", i, pop_count); end
            checks++; if (drop_count !== 16'h0) begin errors++; $display("FAIL reset_drop_count cyc%0d: got %h want 0", i, drop_count); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy cyc%0d: got %b want 0", i, busy); end
        end
        rd_rst = 1'b0;
        tick();
        checks++; if (bus.rd_inc !== 1'b0) begin errors++; $display("FAIL idle_no_pop: got %b want 0", bus.rd_inc); end
        $display("test_reset done: pop_count=%h", pop_count);
        fq.delete();
        drive_fifo();
    endtask

    task automatic test_stream();
        logic [7:0] exp [3];
        exp = '{8'h11, 8'h22, 8'h33};
        fq = '{8'h11, 8'h22, 8'h33};
        drive_fifo();
        en = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.rd_inc !== 1'b0) begin errors++; $display("FAIL stream_idle_first: got %b want 0", bus.rd_inc); end
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.rd_inc !== 1'b1) begin errors++; $display("FAIL stream_rd_inc %0d: got %b want 1", i, bus.rd_inc); end
            if (i > 0) begin
                checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp[i-1]) begin errors++; $display("FAIL stream_out %0d: got v=%b d=%h want v=1 d=%h", i, bus.out_valid, bus.out_data, exp[i-1]); end
            end
            tick();
        end
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h33) begin errors++; $display("FAIL stream_out_last: got v=%b d=%h want v=1 d=33", bus.out_valid, bus.out_data); end
        checks++; if (bus.rd_inc !== 1'b0) begin errors++; $display("FAIL stream_empty_no_pop: got %b want 0", bus.rd_inc); end
        checks++; if (pop_count !== 16'd3) begin errors++; $display("FAIL stream_pop_count: got %0d want 3", pop_count); end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stream_drained: got %b want 0", bus.out_valid); end
        $display("test_stream done: pop_count=%0d", pop_count);
    endtask

    task automatic test_backpressure();
        logic [7:0] exp [5];
        int k;
        exp = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
        bus.out_ready = 1'b0;
        fq = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
        drive_fifo();
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.rd_inc !== 1'b0) begin errors++; $display("FAIL bp_stop_pop %0d: got %b want 0", i, bus.rd_inc); end
            checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h31) begin errors++; $display("FAIL bp_hold %0d: got v=%b d=%h want v=1 d=31", i, bus.out_valid, bus.out_data); end
            tick();
        end
        checks++; if (pop_count !== 16'd5) begin errors++; $display("FAIL bp_two_pops: got %0d want 5", pop_count); end
        bus.out_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 20 && k < 5; c++) begin
            if (bus.out_valid === 1'b1) begin
                checks++; if (bus.out_data !== exp[k]) begin errors++; $display("FAIL bp_order %0d: got %h want %h", k, bus.out_data, exp[k]); end
                k++;
            end
            tick();
        end
        checks++; if (k != 5) begin errors++; $display("FAIL bp_count: got %0d words want 5", k); end
        checks++; if (pop_count !== 16'd8 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_final: got pop=%0d v=%b want pop=8 v=0", pop_count, bus.out_valid); end
        $display("test_backpressure done: delivered %0d words", k);
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        fq = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
        drive_fifo();
        tick();
        tick();
        checks++; if (bus.out_valid !== 1'b1 || fq.size() != 4 || pop_count !== 16'd10) begin errors++; $display("FAIL flush_setup: got v=%b fifo=%0d pop=%0d want v=1 fifo=4 pop=10", bus.out_valid, fq.size(), pop_count); end
        flush = 1'b1;
        #1;
        checks++; if (bus.rd_inc !== 1'b0) begin errors++; $display("FAIL flush_entry_no_pop: got %b want 0", bus.rd_inc); end
        tick();
        flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (busy !== 1'b1 || bus.rd_inc !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_pop %0d: got busy=%b inc=%b v=%b want 1 1 0", i, busy, bus.rd_inc, bus.out_valid); end
            checks++; if (drop_count !== 16'(2 + i)) begin errors++; $display("FAIL flush_drop %0d: got %0d want %0d", i, drop_count, 2 + i); end
            tick();
        end
        checks++; if (busy !== 1'b1 || bus.rd_inc !== 1'b0 || drop_count !== 16'd6) begin errors++; $display("FAIL flush_empty: got busy=%b inc=%b drop=%0d want 1 0 6", busy, bus.rd_inc, drop_count); end
        tick();
        checks++; if (busy !== 1'b0 || pop_count !== 16'd14) begin errors++; $display("FAIL flush_exit: got busy=%b pop=%0d want 0 14", busy, pop_count); end
        bus.out_ready = 1'b1;
        fq.push_back(8'h47);
        drive_fifo();
        #1;
        checks++; if (bus.rd_inc !== 1'b1) begin errors++; $display("FAIL flush_back_to_stream: got %b want 1", bus.rd_inc); end
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h47) begin errors++; $display("FAIL flush_resume_out: got v=%b d=%h want v=1 d=47", bus.out_valid, bus.out_data); end
        tick();
        checks++; if (bus.out_valid !== 1'b0 || pop_count !== 16'd15) begin errors++; $display("FAIL flush_resume_final: got v=%b pop=%0d want 0 15", bus.out_valid, pop_count); end
        $display("test_flush done: drop_count=%0d", drop_count);
    endtask

    task automatic test_empty_arrival();
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus.rd_inc !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL empty_idle %0d: got inc=%b v=%b want 0 0", i, bus.rd_inc, bus.out_valid); end
            tick();
        end
        fq.push_back(8'hA5);
        drive_fifo();
        #1;
        checks++; if (bus.rd_inc !== 1'b1) begin errors++; $display("FAIL arrival_pop: got %b want 1", bus.rd_inc); end
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5) begin errors++; $display("FAIL arrival_out: got v=%b d=%h want v=1 d=a5", bus.out_valid, bus.out_data); end
        checks++; if (bus.rd_inc !== 1'b0 || pop_count !== 16'd16) begin errors++; $display("FAIL arrival_single: got inc=%b pop=%0d want 0 16", bus.rd_inc, pop_count); end
        tick();
        fq.push_back(8'hB1);
        drive_fifo();
        #1;
        checks++; if (bus.rd_inc !== 1'b1) begin errors++; $display("FAIL stale_pre: got %b want 1", bus.rd_inc); end
        fq.delete();
        drive_fifo();
        #1;
        checks++; if (bus.rd_inc !== 1'b0) begin errors++; $display("FAIL stale_gate: got %b want 0", bus.rd_inc); end
        tick();
        checks++; if (bus.out_valid !== 1'b0 || pop_count !== 16'd16) begin errors++; $display("FAIL stale_capture: got v=%b pop=%0d want 0 16", bus.out_valid, pop_count); end
        $display("test_empty_arrival done: pop_count=%0d", pop_count);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 237; i++) fq.push_back(8'(i));
        drive_fifo();
        bus.out_ready = 1'b1;
        for (int c = 0; c < 600 && (fq.size() != 0 || bus.out_valid === 1'b1); c++) tick();
        checks++; if (fq.size() != 0 || pop_count !== 16'h00FD) begin errors++; $display("FAIL bulk_stream: got fifo=%0d pop=%h want 0 00fd", fq.size(), pop_count); end
        bus.out_ready = 1'b0;
        fq = '{8'hC1, 8'hC2, 8'hC3};
        drive_fifo();
        tick();
        tick();
        tick();
        checks++; if (pop_count !== 16'h00FF || bus.out_valid !== 1'b1 || bus.out_data !== 8'hC1) begin errors++; $display("FAIL rst_setup: got pop=%h v=%b d=%h want 00ff 1 c1", pop_count, bus.out_valid, bus.out_data); end
        rd_rst = 1'b1;
        #1;
        checks++; if (bus.rd_inc !== 1'b0) begin errors++; $display("FAIL rst_no_pop: got %b want 0", bus.rd_inc); end
        tick();
        checks++; if (bus.out_valid !== 1'b0 || pop_count !== 16'h0 || drop_count !== 16'h0 || busy !== 1'b0) begin errors++; $display("FAIL rst_clear: got v=%b pop=%h drop=%h busy=%b want all 0", bus.out_valid, pop_count, drop_count, busy); end
        rd_rst = 1'b0;
        tick();
        checks++; if (bus.rd_inc !== 1'b1) begin errors++; $display("FAIL rst_restream: got %b want 1", bus.rd_inc); end
        rd_rst = 1'b1;
        #1;
        checks++; if (bus.rd_inc !== 1'b0) begin errors++; $display("FAIL rst_gates_inc: got %b want 0", bus.rd_inc); end
        tick();
        checks++; if (pop_count !== 16'h0 || fq.size() != 1) begin errors++; $display("FAIL rst_gate_effect: got pop=%h fifo=%0d want 0 1", pop_count, fq.size()); end
        rd_rst = 1'b0;
        $display("test_reset_mid done: pop_count=%h", pop_count);
    endtask

    task automatic test_wrap();
        for (int c = 0; c < 400 && wrap_pop !== 8'hFF; c++) tick();
        checks++; if (wrap_pop !== 8'hFF) begin errors++; $display("FAIL wrap_reach: got %h want ff", wrap_pop); end
        checks++; if (wbus.rd_inc !== 1'b1) begin errors++; $display("FAIL wrap_pop_pending: got %b want 1", wbus.rd_inc); end
        tick();
        checks++; if (wrap_pop !== 8'h00) begin errors++; $display("FAIL wrap_to_zero: got %h want 00", wrap_pop); end
        $display("test_wrap done: wrap pop_count=%h", wrap_pop);
    endtask

    initial begin
        rd_rst = 1'b1;
        en = 1'b0;
        flush = 1'b0;
        bus.out_ready = 1'b0;
        wbus.rd_empty = 1'b0;
        wbus.rd_data = 8'h5A;
        wbus.out_ready = 1'b1;
        drive_fifo();
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_empty_arrival();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
